// File: rtl/bench_pkg.sv
// Shared definitions for the matrix bench command.
//   CHAR_*  : ASCII codes used when decoding input lines and printing results
//   state_t : top-level control states (LOAD rows, MAC one element, EMIT its text)
//   clog2   : elaboration-time ceiling log2, used to size counters and the accumulator
package bench_pkg;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_SP = 8'h20;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bench_bin2dec.sv
// Combinational binary-to-BCD converter (double dabble).
//   bin : unsigned binary value, W bits
//   bcd : ND decimal digits, bcd[ND-1] is the most significant
// The caller guarantees the value fits in ND digits.
module bench_bin2dec #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic [W-1:0]         bin,
  output logic [ND-1:0][3:0]   bcd
);

  always_comb begin
    logic [4*ND-1:0] s;
    // NOTE: blocking assignments are intentional here: each shift step reads
    // the value produced by the previous step within the same evaluation.
    s = '0;
    for (int b = W - 1; b >= 0; b--) begin
      for (int d = 0; d < ND; d++) begin
        if (s[4*d +: 4] >= 4'd5) s[4*d +: 4] = s[4*d +: 4] + 4'd3;
      end
      s = {s[4*ND-2:0], bin[b]};
    end
    bcd = s;
  end

endmodule

// File: rtl/bench_matmul_cmd.sv
// ASCII matrix bench command.
// Takes 2*N text lines (N rows of A, then N rows of B), computes A*B or A+B,
// and streams the result row-major as zero-padded decimal text.
//   clk, rst              : clock, synchronous active-high reset
//   buffer, buffer_valid  : one text line in; digit j sits at [127-16j -: 8]
//   buffer_ready          : high in LOAD, where a line is consumed each valid cycle
//   mode                  : 0 multiply, 1 element-wise add; captured with A row 0
//   print_data/valid/ready: output byte stream with backpressure
//   busy                  : high whenever the block is not waiting for lines
//   err                   : sticky, a non-digit was seen in the current command
//   done                  : one-cycle pulse after the final byte is taken
module bench_matmul_cmd
  import bench_pkg::*;
#(
  parameter int N      = 3,
  parameter int ND     = 3,
  parameter int EOL_LF = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] buffer,
  input  logic         buffer_valid,
  output logic         buffer_ready,
  input  logic         mode,
  output logic [7:0]   print_data,
  output logic         print_valid,
  input  logic         print_ready,
  output logic         busy,
  output logic         err,
  output logic         done
);

  localparam int AW = clog2(N * 81 + 1);
  localparam int IW = (N > 1) ? clog2(N) : 1;
  localparam int RW = (N > 1) ? clog2(2 * N) : 1;
  localparam int CW = clog2(ND + 3);
  localparam logic [IW-1:0] N_M1 = IW'(N - 1);

  state_t               state_q, state_d;
  logic [RW-1:0]        row_cnt;
  logic [IW-1:0]        i_q, j_q, k_q;
  logic [CW-1:0]        c_q;
  logic [AW-1:0]        acc_q;
  logic                 mode_q;
  logic [N-1:0][3:0]    a_q [N];
  logic [N-1:0][3:0]    b_q [N];

  logic [N-1:0][3:0]    row_dig;
  logic                 row_bad;
  logic [ND-1:0][3:0]   bcd;
  logic [CW-1:0]        char_sel;
  logic [7:0]           next_char;
  logic                 accept_row, last_row, last_char, last_elem, mac_done, pv_fire;

  assign buffer_ready = (state_q == LOAD);
  assign busy         = (state_q != LOAD);
  assign accept_row   = buffer_ready && buffer_valid;
  assign last_row     = (row_cnt == RW'(2 * N - 1));
  assign last_elem    = (i_q == N_M1) && (j_q == N_M1);
  assign mac_done     = mode_q || (k_q == N_M1);
  assign pv_fire      = print_valid && print_ready;
  // Last column carries CR (and optionally LF) instead of a single space.
  assign last_char    = (c_q == ((j_q == N_M1) ? CW'(ND + EOL_LF) : CW'(ND)));

  // Decode the first N single-digit fields of the incoming line.
  always_comb begin
    logic [7:0] ch, diff;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    row_dig = '0;
    row_bad = 1'b0;
    for (int j = 0; j < N; j++) begin
      ch   = buffer[127 - 16*j -: 8];
      diff = ch - CHAR_0;
      if (ch >= CHAR_0 && ch <= 8'h39) row_dig[j] = diff[3:0];
      else                             row_bad    = 1'b1;
    end
  end

  bench_bin2dec #(.W(AW), .ND(ND)) u_bin2dec (
    .bin (acc_q),
    .bcd (bcd)
  );

  // Character to present next: the current index when the output register is
  // empty, otherwise the one after the byte being handed off this cycle.
  always_comb begin
    char_sel  = print_valid ? c_q + CW'(1) : c_q;
    next_char = CHAR_LF;
    if (char_sel < CW'(ND)) begin
      for (int d = 0; d < ND; d++)
        if (char_sel == CW'(d)) next_char = CHAR_0 + {4'h0, bcd[ND-1-d]};
    end else if (char_sel == CW'(ND)) begin
      next_char = (j_q == N_M1) ? CHAR_CR : CHAR_SP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (accept_row && last_row) state_d = MAC;
      MAC:     if (mac_done)               state_d = EMIT;
      EMIT:    if (pv_fire && last_char)   state_d = last_elem ? LOAD : MAC;
      default: state_d = LOAD;
    endcase
  end

  // NOTE: matrix storage has no reset; every row is rewritten before it is
  // read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (accept_row) begin
      for (int r = 0; r < N; r++) begin
        if (row_cnt == RW'(r))     a_q[r] <= row_dig;
        if (row_cnt == RW'(N + r)) b_q[r] <= row_dig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      c_q         <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      err         <= 1'b0;
      done        <= 1'b0;
      print_valid <= 1'b0;
      print_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (accept_row) begin
            if (row_cnt == '0) begin
              mode_q <= mode;
              err    <= row_bad;
            end else begin
              err    <= err | row_bad;
            end
            if (last_row) begin
              row_cnt <= '0;
              i_q     <= '0;
              j_q     <= '0;
              k_q     <= '0;
              acc_q   <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        MAC: begin
          if (mode_q) begin
            acc_q <= AW'(a_q[i_q][j_q]) + AW'(b_q[i_q][j_q]);
          end else begin
            acc_q <= acc_q + AW'(a_q[i_q][k_q]) * AW'(b_q[k_q][j_q]);
            k_q   <= (k_q == N_M1) ? '0 : k_q + IW'(1);
          end
          c_q <= '0;
        end
        EMIT: begin
          if (!print_valid) begin
            print_valid <= 1'b1;
            print_data  <= next_char;
          end else if (print_ready) begin
            if (last_char) begin
              print_valid <= 1'b0;
              c_q         <= '0;
              k_q         <= '0;
              acc_q       <= '0;
              if (last_elem) begin
                i_q  <= '0;
                j_q  <= '0;
                done <= 1'b1;
              end else if (j_q == N_M1) begin
                j_q <= '0;
                i_q <= i_q + IW'(1);
              end else begin
                j_q <= j_q + IW'(1);
              end
            end else begin
              c_q        <= c_q + CW'(1);
              print_data <= next_char;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
